// File: rtl/unary_add_multi.sv
// unary_add_multi: multi-lane unary accumulator modulo MOD with serial unary emission.
// Define UNARY_ADD_SAT_EN to saturate at MOD-1 on overflow instead of wrapping.
module unary_add_multi #(
  parameter int LANES = 2,
  parameter int MOD = 6,
  parameter int CW = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             read_or_write,
  input  logic [LANES-1:0] din,
  output logic             dout,
  output logic             C,
  output logic             done,
  output logic [CW-1:0]    count
);
  localparam logic [CW:0] MODW = (CW+1)'(MOD);
  logic [CW:0] pop, sum, acc;
  logic wrap;
  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) pop = pop + (CW+1)'(din[i]);
    sum = {1'b0, count} + pop;
    wrap = sum >= MODW;
`ifdef UNARY_ADD_SAT_EN
    acc = wrap ? MODW - 1'b1 : sum;
`else
    acc = wrap ? sum - MODW : sum;
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      dout <= 1'b0;
      C <= 1'b0;
      done <= 1'b0;
    end else begin
      dout <= en && read_or_write && count != '0;
      done <= en && read_or_write && count == CW'(1);
      C <= en && !read_or_write && wrap;
      if (en) count <= read_or_write ? (count != '0 ? count - 1'b1 : count) : CW'(acc);
    end
  end
endmodule

// File: tb/tb_unary_add_multi.sv
// tb_unary_add_multi: directed self-checking bench for unary_add_multi (LANES=2, MOD=6, CW=3).
module tb_unary_add_multi;
  logic clk = 1'b0, rst_n, en, read_or_write;
  logic [1:0] din;
  logic dout, C, done;
  logic [2:0] count;
  int checks = 0, fails = 0;

  unary_add_multi #(.LANES(2), .MOD(6), .CW(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .read_or_write(read_or_write),
    .din(din), .dout(dout), .C(C), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic w, input logic [1:0] d);
    rst_n = r;
    en = e;
    read_or_write = w;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic expect4(input string tag, input logic [2:0] c, input logic o, input logic cy, input logic dn);
    chk({tag, "_count"}, 8'(count), 8'(c));
    chk({tag, "_dout"}, 8'(dout), 8'(o));
    chk({tag, "_C"}, 8'(C), 8'(cy));
    chk({tag, "_done"}, 8'(done), 8'(dn));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; read_or_write = 1'b0; din = '0;
    step(0, 1, 0, 2'b11);
    step(0, 1, 0, 2'b11);
    expect4("reset", 0, 0, 0, 0);
`ifdef UNARY_ADD_SAT_EN
    step(1, 1, 0, 2'b11); expect4("sat_a1", 2, 0, 0, 0);
    step(1, 1, 0, 2'b11); expect4("sat_a2", 4, 0, 0, 0);
    step(1, 1, 0, 2'b11); expect4("sat_a3", 5, 0, 1, 0);
    step(1, 1, 0, 2'b11); expect4("sat_hold11", 5, 0, 1, 0);
    step(1, 1, 0, 2'b00); expect4("sat_hold00", 5, 0, 0, 0);
    step(1, 1, 0, 2'b01); expect4("sat_repulse", 5, 0, 1, 0);
`else
    step(1, 1, 0, 2'b11); expect4("wrap_a1", 2, 0, 0, 0);
    step(1, 1, 0, 2'b11); expect4("wrap_a2", 4, 0, 0, 0);
    step(1, 1, 0, 2'b11); expect4("wrap_a3", 0, 0, 1, 0);
    step(1, 1, 0, 2'b01); expect4("wrap_a4", 1, 0, 0, 0);
    step(1, 1, 0, 2'b11); expect4("rem_a1", 3, 0, 0, 0);
    step(1, 1, 0, 2'b11); expect4("rem_a2", 5, 0, 0, 0);
    step(1, 1, 0, 2'b11); expect4("rem_wrap", 1, 0, 1, 0);
    step(1, 1, 0, 2'b00); expect4("rem_after", 1, 0, 0, 0);
    step(1, 1, 0, 2'b10); expect4("rem_b", 2, 0, 0, 0);
`endif
    step(0, 1, 0, 2'b00); expect4("clear1", 0, 0, 0, 0);
    step(1, 1, 0, 2'b11); step(1, 1, 0, 2'b01);
    chk("emit_pre_count", 8'(count), 8'd3);
    step(1, 1, 1, 2'b11); expect4("emit1", 2, 1, 0, 0);
    step(1, 1, 1, 2'b11); expect4("emit2", 1, 1, 0, 0);
    step(1, 1, 1, 2'b11); expect4("emit3", 0, 1, 0, 1);
    step(1, 1, 1, 2'b11); expect4("emit4", 0, 0, 0, 0);
    step(1, 1, 1, 2'b11); expect4("emit5", 0, 0, 0, 0);
    step(1, 1, 0, 2'b11); step(1, 1, 0, 2'b11);
    chk("hold_pre_count", 8'(count), 8'd4);
    step(1, 1, 1, 2'b00); expect4("hold_emit1", 3, 1, 0, 0);
    step(1, 0, 1, 2'b11); expect4("hold1", 3, 0, 0, 0);
    step(1, 0, 0, 2'b11); expect4("hold2", 3, 0, 0, 0);
    step(1, 1, 1, 2'b00); expect4("hold_emit2", 2, 1, 0, 0);
    step(1, 1, 0, 2'b01); expect4("switch_acc", 3, 0, 0, 0);
    step(1, 1, 1, 2'b00); expect4("switch_emit", 2, 1, 0, 0);
    step(0, 1, 1, 2'b00); expect4("mid_reset", 0, 0, 0, 0);
    step(1, 1, 1, 2'b00); expect4("post_reset", 0, 0, 0, 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
